// File: rtl/mem_read_responder.sv
// mem_read_responder
// Memory-side responder for the cache burst-read protocol. It takes one burst
// request from the miss handler, issues transSize single-word reads to a
// pipelined memory read port (at most MAX_OUTST in flight), and returns the
// words in order with a one-cycle registered latency. After the last word it
// pulses doneRead.
//
// Ports
//   clk, rst             clock, synchronous active-low reset
//   addr_cache_to_sdram  burst start word address
//   transSize            number of words in the burst (0 = empty burst)
//   readReq              request, held by the requester through doneRead
//   readValid_out        readData valid this cycle
//   readData             returned word (holds when readValid_out is low)
//   doneRead             one-cycle burst-complete pulse
//   mem_addr, mem_rd     memory read address / strobe
//   mem_waitreq          memory stall; mem_rd and mem_addr are held
//   mem_rdata            memory read data
//   mem_rdvalid          mem_rdata valid, in issue order
//
// state | meaning
// IDLE  | waiting for readReq; the only state where a request is sampled
// ISSUE | issuing reads, throttled by the outstanding-read limit
// DRAIN | all reads issued, collecting the remaining returns
// DONE  | doneRead asserted for one cycle
module mem_read_responder #(
  parameter int MAX_TRANS = 16,
  parameter int TS_W      = $clog2(MAX_TRANS),
  parameter int MAX_OUTST = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [24:0]     addr_cache_to_sdram,
  input  logic [TS_W-1:0] transSize,
  input  logic            readReq,
  output logic            readValid_out,
  output logic [31:0]     readData,
  output logic            doneRead,
  output logic [24:0]     mem_addr,
  output logic            mem_rd,
  input  logic            mem_waitreq,
  input  logic [31:0]     mem_rdata,
  input  logic            mem_rdvalid
);

  localparam int OW = $clog2(MAX_OUTST + 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t          state_q, state_d;
  logic [24:0]     addr_q, addr_d;
  logic [TS_W-1:0] len_q, len_d;
  logic [TS_W-1:0] issue_cnt_q, issue_cnt_d;
  logic [TS_W-1:0] ret_cnt_q, ret_cnt_d;
  logic [OW-1:0]   outst_q, outst_d;
  logic            rvalid_q, rvalid_d;
  logic [31:0]     rdata_q, rdata_d;
  logic            accept;
  logic            ret;

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    len_d       = len_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;
    outst_d     = outst_q;
    rdata_d     = rdata_q;

    // Throttle uses the registered count: a return in this cycle frees its
    // slot only from the next cycle on.
    mem_rd = (state_q == ISSUE) && (outst_q < OW'(MAX_OUTST));
    accept = mem_rd && !mem_waitreq;
    // Returns are taken only while a burst is active and still owed words,
    // so stray or late data can never add a readValid_out pulse.
    ret    = mem_rdvalid && ((state_q == ISSUE) || (state_q == DRAIN))
             && (ret_cnt_q != len_q);

    rvalid_d = ret;
    if (ret) begin
      rdata_d   = mem_rdata;
      ret_cnt_d = ret_cnt_q + TS_W'(1);
    end

    if (accept) begin
      addr_d      = addr_q + 25'd1;
      issue_cnt_d = issue_cnt_q + TS_W'(1);
    end

    case ({accept, ret})
      2'b10:   outst_d = outst_q + OW'(1);
      2'b01:   outst_d = outst_q - OW'(1);
      default: outst_d = outst_q;
    endcase

    unique case (state_q)
      IDLE: begin
        if (readReq) begin
          if (transSize != '0) begin
            state_d     = ISSUE;
            addr_d      = addr_cache_to_sdram;
            len_d       = transSize;
            issue_cnt_d = '0;
            ret_cnt_d   = '0;
            outst_d     = '0;
          end else begin
            state_d = DONE;
          end
        end
      end
      ISSUE: begin
        if (accept && ((issue_cnt_q + TS_W'(1)) == len_q)) state_d = DRAIN;
      end
      // Leave DRAIN one cycle after the last return is captured, i.e. while
      // the final word is on readValid_out, so doneRead follows it.
      DRAIN: begin
        if (ret_cnt_q == len_q) state_d = DONE;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      len_q       <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      outst_q     <= '0;
      rvalid_q    <= 1'b0;
      rdata_q     <= '0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      outst_q     <= outst_d;
      rvalid_q    <= rvalid_d;
      rdata_q     <= rdata_d;
    end
  end

  assign mem_addr      = addr_q;
  assign readValid_out = rvalid_q;
  assign readData      = rdata_q;
  assign doneRead      = (state_q == DONE);

endmodule

// File: tb/tb_mem_read_responder.sv
module tb_mem_read_responder;

  logic        clk = 1'b0;
  logic        rst;
  logic [24:0] addr;
  logic [3:0]  tsize;
  logic        req;
  logic        rv;
  logic [31:0] rdata;
  logic        done;
  logic [24:0] maddr;
  logic        mrd;
  logic        wreq;
  logic [31:0] mrdata;
  logic        mrdv;

  always #5 clk = ~clk;

  mem_read_responder #(.MAX_TRANS(16), .TS_W(4), .MAX_OUTST(4)) dut (
    .clk                 (clk),
    .rst                 (rst),
    .addr_cache_to_sdram (addr),
    .transSize           (tsize),
    .readReq             (req),
    .readValid_out       (rv),
    .readData            (rdata),
    .doneRead            (done),
    .mem_addr            (maddr),
    .mem_rd              (mrd),
    .mem_waitreq         (wreq),
    .mem_rdata           (mrdata),
    .mem_rdvalid         (mrdv)
  );

  int n_cmp = 0;
  int n_bad = 0;

  int cyc = 0;
  int lat = 2;
  int stall_lo = -1;
  int stall_hi = -1;
  int stray_cyc = -1;

  logic [24:0] pend_addr[$];
  int          pend_due[$];
  logic [24:0] acc_addr[$];
  int          acc_cyc[$];
  logic [31:0] rv_data[$];
  int          last_rv = -1;
  int          done_cyc = -1;
  int          done_cnt = 0;
  int          max_infl = 0;
  int          hold_viol = 0;
  logic        prev_stall = 1'b0;
  logic [24:0] prev_addr = '0;

  // Memory model and output monitor. Inputs are driven on the falling edge
  // and sampled by the DUT on the next rising edge; read data returns lat
  // cycles after acceptance with data = 0xD0000000 ^ address.
  initial begin
    mrdv = 1'b0;
    mrdata = '0;
    wreq = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      if (rv === 1'b1) begin
        rv_data.push_back(rdata);
        last_rv = cyc;
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (pend_due.size() > 0 && pend_due[0] == cyc) begin
        mrdv = 1'b1;
        mrdata = 32'hD000_0000 ^ {7'd0, pend_addr[0]};
        void'(pend_due.pop_front());
        void'(pend_addr.pop_front());
      end else if (cyc == stray_cyc) begin
        mrdv = 1'b1;
        mrdata = 32'hBADB_AD00;
      end else begin
        mrdv = 1'b0;
      end
      if (prev_stall && (mrd !== 1'b1 || maddr !== prev_addr)) hold_viol++;
      wreq = (cyc >= stall_lo) && (cyc <= stall_hi);
      prev_stall = (mrd === 1'b1) && wreq;
      prev_addr = maddr;
      if (mrd === 1'b1 && !wreq) begin
        pend_addr.push_back(maddr);
        pend_due.push_back(cyc + lat);
        acc_addr.push_back(maddr);
        acc_cyc.push_back(cyc);
        if (pend_due.size() > max_infl) max_infl = pend_due.size();
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic clear_log();
    acc_addr.delete();
    acc_cyc.delete();
    rv_data.delete();
    done_cnt = 0;
    done_cyc = -1;
    last_rv = -1;
    max_infl = 0;
    hold_viol = 0;
  endtask

  task automatic start(input logic [24:0] a, input logic [3:0] n, output int r);
    @(negedge clk);
    #1;
    addr = a;
    tsize = n;
    req = 1'b1;
    r = cyc;
  endtask

  task automatic wait_done(input string tag);
    int k;
    k = 0;
    while (done_cnt == 0 && k < 300) begin
      @(negedge clk);
      #1;
      k++;
    end
    n_cmp++;
    assert (done_cnt != 0) else begin
      n_bad++;
      $error("FAIL %s: doneRead observed 0 times within %0d cycles, expected 1", tag, k);
    end
  endtask

  task automatic idle_step();
    @(negedge clk);
    #1;
    req = 1'b0;
  endtask

  int r;
  int d;
  int k;

  initial begin
    rst = 1'b0;
    req = 1'b0;
    addr = '0;
    tsize = '0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_valid", rv, 0);
    chk("rst_done", done, 0);
    chk("rst_mem_rd", mrd, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_mem_addr", maddr, 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    // 1: basic burst, latency 2
    clear_log();
    lat = 2;
    start(25'h100, 4'd8, r);
    wait_done("t1_done");
    chk("t1_n_issued", acc_addr.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_addr", acc_addr[i], 25'h100 + 25'(i));
    chk("t1_n_words", rv_data.size(), 8);
    for (int i = 0; i < 8; i++) chk("t1_data", rv_data[i], 32'hD000_0100 + 32'(i));
    chk("t1_done_cyc", done_cyc, r + 12);
    chk("t1_done_after_last", done_cyc, last_rv + 1);
    chk("t1_max_inflight", max_infl, 2);
    idle_step();
    chk("t1_idle_mem_rd", mrd, 0);
    chk("t1_idle_done", done, 0);
    chk("t1_rdata_hold", rdata, 32'hD000_0107);
    chk("t1_done_count", done_cnt, 1);

    // 2: waitreq stalls on cycles 2-4 of the burst
    clear_log();
    start(25'h100, 4'd8, r);
    stall_lo = r + 2;
    stall_hi = r + 4;
    wait_done("t2_done");
    chk("t2_hold_violations", hold_viol, 0);
    chk("t2_n_issued", acc_addr.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_addr", acc_addr[i], 25'h100 + 25'(i));
    chk("t2_resume_cyc", acc_cyc[1], r + 5);
    chk("t2_n_words", rv_data.size(), 8);
    for (int i = 0; i < 8; i++) chk("t2_data", rv_data[i], 32'hD000_0100 + 32'(i));
    chk("t2_done_cyc", done_cyc, r + 15);
    idle_step();
    stall_lo = -1;
    stall_hi = -1;

    // 3: outstanding limit, transSize 12, latency 10
    clear_log();
    lat = 10;
    start(25'h040, 4'd12, r);
    wait_done("t3_done");
    chk("t3_n_issued", acc_addr.size(), 12);
    chk("t3_max_inflight", max_infl, 4);
    chk("t3_acc3_cyc", acc_cyc[3], r + 4);
    chk("t3_acc4_cyc", acc_cyc[4], r + 12);
    chk("t3_acc7_cyc", acc_cyc[7], r + 15);
    chk("t3_acc8_cyc", acc_cyc[8], r + 23);
    chk("t3_n_words", rv_data.size(), 12);
    chk("t3_data_last", rv_data[11], 32'hD000_004B);
    chk("t3_done_cyc", done_cyc, r + 38);
    idle_step();
    lat = 2;

    // 4: zero-length burst
    clear_log();
    start(25'h123, 4'd0, r);
    wait_done("t4_done");
    chk("t4_done_cyc", done_cyc, r + 1);
    chk("t4_n_issued", acc_addr.size(), 0);
    chk("t4_n_words", rv_data.size(), 0);
    idle_step();
    chk("t4_idle_done", done, 0);

    // 5: reset after 3 of 8 words, then a wrapping burst
    clear_log();
    start(25'h100, 4'd8, r);
    k = 0;
    while (rv_data.size() < 3 && k < 100) begin
      @(negedge clk);
      #1;
      k++;
    end
    chk("t5_three_words", rv_data.size(), 3);
    rst = 1'b0;
    req = 1'b0;
    @(negedge clk);
    #1;
    chk("t5_rst_valid", rv, 0);
    chk("t5_rst_done", done, 0);
    chk("t5_rst_mem_rd", mrd, 0);
    chk("t5_rst_rdata", rdata, 0);
    chk("t5_rst_mem_addr", maddr, 0);
    rst = 1'b1;
    repeat (6) @(negedge clk);
    #1;
    chk("t5_late_dropped", rv_data.size(), 3);
    chk("t5_no_done", done_cnt, 0);
    clear_log();
    start(25'h1FF_FFFF, 4'd2, r);
    wait_done("t5w_done");
    chk("t5w_n_issued", acc_addr.size(), 2);
    chk("t5w_addr0", acc_addr[0], 25'h1FF_FFFF);
    chk("t5w_addr1", acc_addr[1], 25'h000_0000);
    chk("t5w_n_words", rv_data.size(), 2);
    chk("t5w_data0", rv_data[0], 32'hD1FF_FFFF);
    chk("t5w_data1", rv_data[1], 32'hD000_0000);
    chk("t5w_done_cyc", done_cyc, r + 6);
    idle_step();

    // 6: back-to-back request with a stray return in the idle cycle
    clear_log();
    start(25'h300, 4'd3, r);
    wait_done("t6a_done");
    chk("t6a_n_words", rv_data.size(), 3);
    d = cyc;
    stray_cyc = d + 1;
    @(negedge clk);
    #1;
    clear_log();
    addr = 25'h200;
    tsize = 4'd4;
    req = 1'b1;
    r = cyc;
    wait_done("t6b_done");
    chk("t6b_start_cyc", r, d + 1);
    chk("t6b_n_issued", acc_addr.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6b_addr", acc_addr[i], 25'h200 + 25'(i));
    chk("t6b_n_words", rv_data.size(), 4);
    for (int i = 0; i < 4; i++) chk("t6b_data", rv_data[i], 32'hD000_0200 + 32'(i));
    chk("t6b_done_cyc", done_cyc, r + 8);
    idle_step();
    repeat (2) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
